// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one external ALU among four requesters. An idle arbiter grants one
// request (round-robin from rr_ptr), holds that requester's operands on the
// ALU for ALU_LAT+1 cycles, and captures the ALU outputs into a response
// register. The response is held until the consumer accepts it.
// ALU_LAT is the number of ALU pipeline edges, legal range 1..7.
module alu_share_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [7:0]  req_op,
  output logic [3:0]  req_ready,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [1:0]  alu_op,
  input  logic [3:0]  alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_id,
  output logic [3:0]  rsp_result,
  output logic [2:0]  rsp_flags,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // The last EXEC cycle is the one where the counter reads zero, so loading
  // ALU_LAT gives ALU_LAT+1 EXEC cycles in total.
  localparam logic [2:0] EXEC_LOAD = 3'(ALU_LAT);

  logic [1:0]  state_r;
  logic [1:0]  rr_ptr_r;
  logic [2:0]  cnt_r;
  logic [1:0]  id_r;
  logic [3:0]  alu_a_r;
  logic [3:0]  alu_b_r;
  logic [1:0]  alu_op_r;
  logic        rsp_valid_r;
  logic [1:0]  rsp_id_r;
  logic [3:0]  rsp_result_r;
  logic [2:0]  rsp_flags_r;
  logic        busy_r;
  logic [15:0] op_count_r;

  logic [1:0]  idx_s;
  logic        found_s;
  logic [1:0]  grant_id_s;
  logic [3:0]  grant_s;
  logic        grant_valid_s;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping mod 4.
  // The grant is suppressed outside IDLE and while reset is asserted.
  always_comb begin
    idx_s      = 2'd0;
    found_s    = 1'b0;
    grant_id_s = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx_s = rr_ptr_r + 2'(k);
      if (!found_s && req_valid[idx_s]) begin
        found_s    = 1'b1;
        grant_id_s = idx_s;
      end else begin
        found_s    = found_s;
        grant_id_s = grant_id_s;
      end
    end
    if (found_s && (state_r == IDLE) && rst_n) begin
      grant_s = 4'b0001 << grant_id_s;
    end else begin
      grant_s = 4'b0000;
    end
    grant_valid_s = |grant_s;
  end

  assign req_ready  = grant_s;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_op     = alu_op_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_flags  = rsp_flags_r;
  assign busy       = busy_r;
  assign op_count   = op_count_r;

  // Control FSM with operand, response and completion-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      rr_ptr_r     <= 2'd0;
      cnt_r        <= 3'd0;
      id_r         <= 2'd0;
      alu_a_r      <= 4'd0;
      alu_b_r      <= 4'd0;
      alu_op_r     <= 2'd0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 2'd0;
      rsp_result_r <= 4'd0;
      rsp_flags_r  <= 3'd0;
      busy_r       <= 1'b0;
      op_count_r   <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            alu_a_r  <= req_a[{grant_id_s, 2'b00} +: 4];
            alu_b_r  <= req_b[{grant_id_s, 2'b00} +: 4];
            alu_op_r <= req_op[{grant_id_s, 1'b0} +: 2];
            id_r     <= grant_id_s;
            rr_ptr_r <= grant_id_s + 2'd1;
            cnt_r    <= EXEC_LOAD;
            busy_r   <= 1'b1;
            state_r  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_r == 3'd0) begin
            rsp_result_r <= alu_result;
            rsp_flags_r  <= {alu_carry, alu_zero, alu_overflow};
            rsp_id_r     <= id_r;
            rsp_valid_r  <= 1'b1;
            state_r      <= RESP;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            op_count_r  <= op_count_r + 16'd1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean idle state.
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          cnt_r       <= 3'd0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 The block SHALL have parameter ALU_LAT, default 1, meaning clock edges from ALU operand sampling to valid ALU outputs; legal range 1..7.
REQ-002 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port req_valid  input  4  per-requester request valid; bit i is requester i.
REQ-005 The block SHALL have port req_a  input  16  operand A per requester; requester i in bits [4i+3:4i].
REQ-006 The block SHALL have port req_b  input  16  operand B per requester, same packing as req_a.
REQ-007 The block SHALL have port req_op  input  8  op per requester; requester i in bits [2i+1:2i].
REQ-008 The block SHALL have port req_ready  output  4  one-hot accept strobe; request i is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-009 The block SHALL have ports alu_a  output  4, alu_b  output  4 and alu_op  output  2, which are the operands and op driven to the shared ALU.
REQ-010 The block SHALL have ports alu_result  input  4, alu_carry  input  1, alu_zero  input  1 and alu_overflow  input  1, which are the ALU outputs.
REQ-011 The block SHALL have port rsp_valid  output  1  response valid.
REQ-012 The block SHALL have port rsp_ready  input  1  response consumer ready.
REQ-013 The block SHALL have port rsp_id  output  2  index of the requester that owns the response.
REQ-014 The block SHALL have port rsp_result  output  4  captured ALU result.
REQ-015 The block SHALL have port rsp_flags  output  3  captured {carry, zero, overflow}.
REQ-016 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 The block SHALL have port op_count  output  16  count of completed responses.

Function
REQ-018 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-019 IDLE SHALL arbitrate round-robin when any req_valid bit is 1; priority starts at rr_ptr and rotates upward mod 4.
REQ-020 IDLE SHALL assert req_ready combinationally in the same cycle, for the granted requester only.
REQ-021 At the IDLE grant edge, the block SHALL register the granted requester's A, B, op and id, set rr_ptr to grant+1 mod 4, and enter EXEC.
REQ-022 req_ready SHALL be 0 in EXEC and RESP, and in IDLE when req_valid is 0.
REQ-023 alu_a, alu_b and alu_op SHALL be driven from the operand registers and held stable from the first EXEC cycle until the next grant.
REQ-024 EXEC SHALL last exactly ALU_LAT+1 cycles, timed by a 3-bit down-counter.
REQ-025 On the edge ending the last EXEC cycle, the block SHALL capture alu_result and the three flags into the rsp registers and enter RESP.
REQ-026 RESP SHALL hold rsp_valid=1; rsp_id, rsp_result and rsp_flags SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-027 On a RESP cycle with rsp_ready=1, the block SHALL drop rsp_valid at the next edge, increment op_count, and return to IDLE.
REQ-028 No grant SHALL occur in the handshake cycle; the next grant is earliest one cycle later.
REQ-029 Latency SHALL be: grant in cycle t gives rsp_valid first high in cycle t+ALU_LAT+2; with ALU_LAT=1 and rsp_ready tied 1, one operation completes every 4 cycles.
REQ-030 op_count SHALL wrap from 0xFFFF to 0x0000 without saturation.
REQ-031 Changes on req_valid, req_a, req_b or req_op during EXEC or RESP SHALL have no effect on the in-flight operation.
REQ-032 A requester that deasserts req_valid before being granted SHALL simply lose its turn; rr_ptr SHALL change only on a grant.

Reset
REQ-033 On rst_n low, asynchronously: state=IDLE, rr_ptr=0, counter=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, alu_a=0, alu_b=0, alu_op=0, op_count=0, busy=0.
REQ-034 req_ready SHALL be 0 while rst_n is low.
REQ-035 Reset during EXEC or RESP SHALL discard the in-flight operation with no response; the first grant after release SHALL go to the lowest valid index.

Verification
REQ-036 Single request: req_valid=0001, A=3, B=4, op=add, ALU_LAT=1, rsp_ready=1 -> req_ready=0001 in cycle t; rsp_valid in t+3 with rsp_id=0, rsp_result=7, flags=000; op_count=1.
REQ-037 All four valid continuously from reset, rsp_ready=1 -> grant order 0,1,2,3,0,1; rsp_id follows the same order; one grant every 4 cycles.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data held constant, req_ready stays 0000; completes on the cycle rsp_ready=1.
REQ-039 Flags: A=8, B=8, add -> rsp_result=0, flags {carry=1, zero=1, overflow=1}.
REQ-040 Reset pulse in the second EXEC cycle -> no rsp_valid, op_count=0; after release, a req_valid=1010 request is granted to requester 1.
REQ-041 Wrap: force 65536 completions (or preload via a test hook) -> op_count reads 0x0000 after the 65536th handshake.
